dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the pipeline's MEM-stage request interface.
- Accepts the read and write strobes the decoded control word drives (read_memory / write_memory), plus address, write data and byte enables.
- Serves requests from an internal word array after a fixed, parameterised latency, answering with a single-cycle mem_resp.
- Stands in for data memory during pipeline bring-up, and is the reference responder for stall and hazard testing.

Parameters:
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.
- ADDR_WORDS_LOG2, 8, log2 of the array depth in 16-bit words (default 256 words).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  read request; held by the requester until mem_resp
- mem_write  in  1  write request; held by the requester until mem_resp
- mem_address  in  16  byte address; bit 0 ignored for the word index
- mem_wdata  in  16  write data
- mem_byte_enable  in  2  [1] writes the high byte, [0] writes the low byte
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  16  read data; valid only while mem_resp=1
- busy  out  1  high while a request is accepted and not yet answered
- protocol_error  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous assert): mem_resp=0, mem_rdata=0, busy=0, protocol_error=0, state=IDLE, latency counter=0.
  - Array contents are NOT reset.
  - Asserting rst mid-request abandons the request; a pending write is not committed.
- Word index = mem_address[ADDR_WORDS_LOG2:1]. Upper address bits are ignored, so addresses alias modulo the array size.
- State machine: IDLE, WAIT, RESP.
  - IDLE: if mem_read or mem_write is high, capture address, wdata, byte enable and operation; load counter with LATENCY-1; set busy=1. Go to RESP if LATENCY=1, else WAIT.
  - WAIT: decrement the counter each cycle; when it reaches 1, go to RESP.
  - RESP: mem_resp=1 for exactly this cycle, then go to IDLE with busy=0.
- Latency: a request first seen high in cycle 0 while IDLE gets mem_resp high in cycle LATENCY.
- Read: mem_rdata is registered from the array on the edge entering RESP, returns to 0 the cycle after, and is 0 for writes.
- Write: committed on the edge entering RESP; only the byte lanes enabled by mem_byte_enable are written. Byte enable 2'b00 still produces mem_resp but changes nothing.
- Back-to-back requests: the cycle after RESP is IDLE, so a request asserted then is accepted as a new request with no bubble cycle.
  - The requester must drop or replace its request the cycle after mem_resp, otherwise the same request is served twice.
- Read and write asserted together: treated as a write.
- Captured values are used for the whole request; input changes during WAIT or RESP have no effect on the transaction.

Optional Feature:
- Macro: DMEM_PROTOCOL_CHECK_EN.
- Defined: protocol_error goes to 1 on the clock edge following any of these, and stays 1 until rst:
  - (a) mem_read and mem_write high in the same cycle while IDLE;
  - (b) both strobes low while WAIT or RESP;
  - (c) mem_address, mem_wdata, mem_byte_enable, or the operation differing from the captured values while WAIT or RESP.
- Undefined: protocol_error is tied to 0 and no checking logic is built; all other behaviour is identical.

Test Plan:
- LATENCY=3: write 0x1234 to 0x0040 with byte enable 2'b11, then read 0x0040 → each mem_resp lands exactly 3 cycles after its request, and the read returns mem_rdata=0x1234.
- Word 0x0040=0x1234, write 0xABCD to 0x0041 with byte enable 2'b10 (bit 0 ignored, same word), then read 0x0040 → 0xAB34.
- LATENCY=1: four back-to-back reads of 0x0000, 0x0002, 0x0004, 0x0006, each request asserted the cycle after the previous mem_resp → mem_resp high every second cycle, data in order, busy toggling.
- ADDR_WORDS_LOG2=8: write 0x5555 to 0x0010, then read 0x0210 → 0x5555 (aliasing).
- rst asserted during WAIT of a write of 0xFFFF to 0x0020 (previously 0x0000) → mem_resp and busy drop immediately; a later read of 0x0020 returns 0x0000.
- With DMEM_PROTOCOL_CHECK_EN defined: change mem_address from 0x0010 to 0x0012 during WAIT → protocol_error=1 from the next edge and sticky; the transaction still completes to 0x0010.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage request interface.
// Serves reads/writes from an internal 16-bit word array after LATENCY cycles
// and answers with a single-cycle mem_resp.
// Optional feature macro: DMEM_PROTOCOL_CHECK_EN (sticky requester protocol checker).
module dmem_responder #(
  parameter int unsigned LATENCY         = 3,
  parameter int unsigned ADDR_WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        busy,
  output logic        protocol_error
);

  localparam int unsigned WORDS = 1 << ADDR_WORDS_LOG2;
  localparam int unsigned IDX_W = ADDR_WORDS_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [15:0]        wdata_q;
  logic [1:0]         be_q;
  logic               wr_q;

  logic               accept;
  logic [IDX_W-1:0]   txn_idx;
  logic [15:0]        txn_wdata;
  logic [1:0]         txn_be;
  logic               txn_wr;
  logic               resp_d;
  logic               busy_d;
  logic               mem_we;
  logic [15:0]        rdata_d;

  logic [15:0]        mem [WORDS];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address;

  // Next state, counter and registered-output values; in IDLE the live inputs
  // form the transaction so LATENCY=1 can respond without a capture cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    txn_idx   = idx_q;
    txn_wdata = wdata_q;
    txn_be    = be_q;
    txn_wr    = wr_q;
    case (state_q)
      IDLE: begin
        txn_idx   = mem_address[IDX_W:1];
        txn_wdata = mem_wdata;
        txn_be    = mem_byte_enable;
        txn_wr    = mem_write;
        if (mem_read || mem_write) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_d  = (state_d == RESP);
    busy_d  = (state_d != IDLE);
    mem_we  = resp_d && txn_wr && !rst;
    rdata_d = (resp_d && !txn_wr) ? mem[txn_idx] : 16'h0000;
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wr_q      <= 1'b0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= mem_address[IDX_W:1];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        wr_q    <= mem_write;
      end
      mem_resp  <= resp_d;
      mem_rdata <= rdata_d;
      busy      <= busy_d;
    end
  end

  // Byte-lane write commit on the edge entering RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (txn_be[1]) mem[txn_idx][15:8] <= txn_wdata[15:8];
      if (txn_be[0]) mem[txn_idx][7:0]  <= txn_wdata[7:0];
    end
  end

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic [15:0] addr_q;
  logic        err_q;
  logic        violation;

  // Full address is kept only for comparison against the held request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         addr_q <= '0;
    else if (accept) addr_q <= mem_address;
  end

  // Requester misbehaviour: both strobes in IDLE, or a dropped/altered request mid-transaction.
  always_comb begin
    violation = 1'b0;
    if (state_q == IDLE) begin
      violation = mem_read && mem_write;
    end else begin
      violation = (!mem_read && !mem_write) ||
                  (mem_address != addr_q) ||
                  (mem_wdata != wdata_q) ||
                  (mem_byte_enable != be_q) ||
                  (mem_write != wr_q);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | violation;
  end

  assign protocol_error = err_q;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder.
// Two instances: u_a with LATENCY=3, u_b with LATENCY=1 (back-to-back traffic).
module tb_dmem_responder;

  localparam int unsigned LAT_A = 3;
  localparam int unsigned LAT_B = 1;
`ifdef DMEM_PROTOCOL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_read, a_write, a_resp, a_busy, a_perr;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_be;
  logic        b_read, b_write, b_resp, b_busy, b_perr;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_be;

  int errors = 0;
  int checks = 0;

  // Reference model: one word array per instance, plus "known" flags for random reads.
  logic [15:0] ref_a [256];
  logic [15:0] ref_b [256];
  bit          known_a [256];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(LAT_A), .ADDR_WORDS_LOG2(8)) u_a (
    .clk(clk), .rst(rst), .mem_read(a_read), .mem_write(a_write),
    .mem_address(a_addr), .mem_wdata(a_wdata), .mem_byte_enable(a_be),
    .mem_resp(a_resp), .mem_rdata(a_rdata), .busy(a_busy), .protocol_error(a_perr)
  );

  dmem_responder #(.LATENCY(LAT_B), .ADDR_WORDS_LOG2(8)) u_b (
    .clk(clk), .rst(rst), .mem_read(b_read), .mem_write(b_write),
    .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
    .mem_resp(b_resp), .mem_rdata(b_rdata), .busy(b_busy), .protocol_error(b_perr)
  );

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % 256;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[1]) r[15:8] = d[15:8];
    if (be[0]) r[7:0]  = d[7:0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on u_a, hold it until mem_resp (bounded), then drop it.
  // Returns the response cycle (0 if none) and the count of non-busy waiting cycles.
  task automatic req_a(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] be,
                       output int lat, output logic [15:0] rdata, output int busy_bad);
    a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
    lat = 0; rdata = 16'hxxxx; busy_bad = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (a_busy !== 1'b1) busy_bad++;
      if (a_resp === 1'b1) begin
        lat = i;
        rdata = a_rdata;
      end
    end
    a_read = 1'b0; a_write = 1'b0;
    if (wr) begin
      ref_a[widx(addr)] = merge(ref_a[widx(addr)], wd, be);
      if (be == 2'b11) known_a[widx(addr)] = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (a_resp !== 1'b0 || a_busy !== 1'b0 || a_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_a: got resp=%b busy=%b rdata=%h want 0 0 0000", a_resp, a_busy, a_rdata); end
    checks++; if (a_perr !== 1'b0) begin
      errors++; $display("FAIL reset_a_perr: got %b want 0", a_perr); end
    checks++; if (b_resp !== 1'b0 || b_busy !== 1'b0 || b_rdata !== 16'h0 || b_perr !== 1'b0) begin
      errors++; $display("FAIL reset_b: got resp=%b busy=%b rdata=%h perr=%b want all 0", b_resp, b_busy, b_rdata, b_perr); end
    rst = 1'b0;
    step();
    checks++; if (a_busy !== 1'b0 || a_resp !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b resp=%b want 0 0", a_busy, a_resp); end
  endtask

  task automatic test_write_read();
    int lat, bb;
    logic [15:0] rd, exp;
    req_a(1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, lat, rd, bb);
    checks++; if (lat != LAT_A || bb != 0) begin
      errors++; $display("FAIL wr_latency: got lat=%0d busy_gaps=%0d want %0d 0", lat, bb, LAT_A); end
    checks++; if (rd !== 16'h0000) begin
      errors++; $display("FAIL wr_rdata_zero: got %h want 0000", rd); end
    step();
    checks++; if (a_resp !== 1'b0 || a_busy !== 1'b0 || a_rdata !== 16'h0) begin
      errors++; $display("FAIL wr_after_resp: got resp=%b busy=%b rdata=%h want 0 0 0000", a_resp, a_busy, a_rdata); end
    exp = ref_a[widx(16'h0040)];
    req_a(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (lat != LAT_A || bb != 0) begin
      errors++; $display("FAIL rd_latency: got lat=%0d busy_gaps=%0d want %0d 0", lat, bb, LAT_A); end
    checks++; if (rd !== exp) begin
      errors++; $display("FAIL rd_full_word: got %h want %h", rd, exp); end
    step();
    checks++; if (a_rdata !== 16'h0 || a_resp !== 1'b0) begin
      errors++; $display("FAIL rd_data_clears: got rdata=%h resp=%b want 0000 0", a_rdata, a_resp); end
    // High-lane write through the odd byte address of the same word.
    req_a(1'b0, 1'b1, 16'h0041, 16'hABCD, 2'b10, lat, rd, bb);
    step();
    exp = ref_a[widx(16'h0040)];
    req_a(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp) begin
      errors++; $display("FAIL byte_lane_hi: got %h want %h", rd, exp); end
    step();
    // Byte enable 00 responds but leaves the word untouched.
    req_a(1'b0, 1'b1, 16'h0040, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (lat != LAT_A) begin
      errors++; $display("FAIL be00_resp: got lat=%0d want %0d", lat, LAT_A); end
    step();
    exp = ref_a[widx(16'h0040)];
    req_a(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp) begin
      errors++; $display("FAIL be00_nochange: got %h want %h", rd, exp); end
    step();
  endtask

  task automatic test_alias();
    int lat, bb;
    logic [15:0] rd, exp;
    req_a(1'b0, 1'b1, 16'h0010, 16'h5555, 2'b11, lat, rd, bb);
    step();
    exp = ref_a[widx(16'h0210)];
    req_a(1'b1, 1'b0, 16'h0210, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp || lat != LAT_A) begin
      errors++; $display("FAIL alias: got rdata=%h lat=%0d want %h %0d", rd, lat, exp, LAT_A); end
    step();
  endtask

  task automatic test_random();
    int lat, bb;
    logic [15:0] rd, addr, wd, exp;
    logic [1:0] be;
    logic wr;
    for (int n = 0; n < 40; n++) begin
      addr = 16'($urandom);
      addr[8:4] = 5'b11000;
      wr = !known_a[widx(addr)] || ($urandom_range(0, 1) == 1);
      wd = 16'($urandom);
      be = known_a[widx(addr)] ? 2'($urandom) : 2'b11;
      exp = wr ? 16'h0000 : ref_a[widx(addr)];
      req_a(!wr, wr, addr, wd, be, lat, rd, bb);
      checks++; if (lat != LAT_A || bb != 0) begin
        errors++; $display("FAIL rand_latency[%0d]: got lat=%0d busy_gaps=%0d want %0d 0", n, lat, bb, LAT_A); end
      checks++; if (rd !== exp) begin
        errors++; $display("FAIL rand_rdata[%0d] addr=%h wr=%b: got %h want %h", n, addr, wr, rd, exp); end
      step();
      checks++; if (a_resp !== 1'b0 || a_busy !== 1'b0 || a_rdata !== 16'h0) begin
        errors++; $display("FAIL rand_idle[%0d]: got resp=%b busy=%b rdata=%h want 0 0 0000", n, a_resp, a_busy, a_rdata); end
      repeat ($urandom_range(0, 2)) step();
    end
    checks++; if (a_perr !== 1'b0) begin
      errors++; $display("FAIL rand_no_perr: got %b want 0", a_perr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    // Seed words 0..3 on u_b with LATENCY=1 writes.
    for (int k = 0; k < 4; k++) begin
      d = 16'($urandom);
      b_write = 1'b1; b_read = 1'b0; b_addr = 16'(2 * k); b_wdata = d; b_be = 2'b11;
      step();
      checks++; if (b_resp !== 1'b1 || b_rdata !== 16'h0) begin
        errors++; $display("FAIL b2b_wr_resp[%0d]: got resp=%b rdata=%h want 1 0000", k, b_resp, b_rdata); end
      ref_b[widx(16'(2 * k))] = d;
      b_write = 1'b0;
      step();
    end
    // Four reads, each asserted the cycle after the previous response.
    for (int k = 0; k < 4; k++) begin
      b_read = 1'b1; b_addr = 16'(2 * k);
      step();
      checks++; if (b_resp !== 1'b1 || b_busy !== 1'b1 || b_rdata !== ref_b[widx(16'(2 * k))]) begin
        errors++; $display("FAIL b2b_rd[%0d]: got resp=%b busy=%b rdata=%h want 1 1 %h",
                           k, b_resp, b_busy, b_rdata, ref_b[widx(16'(2 * k))]); end
      b_read = 1'b0;
      step();
      checks++; if (b_resp !== 1'b0 || b_busy !== 1'b0 || b_rdata !== 16'h0) begin
        errors++; $display("FAIL b2b_gap[%0d]: got resp=%b busy=%b rdata=%h want 0 0 0000", k, b_resp, b_busy, b_rdata); end
    end
    checks++; if (b_perr !== 1'b0) begin
      errors++; $display("FAIL b2b_no_perr: got %b want 0", b_perr); end
  endtask

  task automatic test_reset_mid();
    int lat, bb;
    logic [15:0] rd, exp;
    req_a(1'b0, 1'b1, 16'h0020, 16'h0000, 2'b11, lat, rd, bb);
    step();
    a_write = 1'b1; a_addr = 16'h0020; a_wdata = 16'hFFFF; a_be = 2'b11;
    step();
    step();
    checks++; if (a_busy !== 1'b1 || a_resp !== 1'b0) begin
      errors++; $display("FAIL mid_wait: got busy=%b resp=%b want 1 0", a_busy, a_resp); end
    rst = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0 || a_resp !== 1'b0 || a_rdata !== 16'h0) begin
      errors++; $display("FAIL mid_rst_drop: got busy=%b resp=%b rdata=%h want 0 0 0000", a_busy, a_resp, a_rdata); end
    a_write = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    exp = ref_a[widx(16'h0020)];
    req_a(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp || lat != LAT_A) begin
      errors++; $display("FAIL mid_rst_nowrite: got rdata=%h lat=%0d want %h %0d", rd, lat, exp, LAT_A); end
    step();
  endtask

  task automatic test_capture();
    int lat, bb;
    logic [15:0] rd, d, exp;
    req_a(1'b0, 1'b1, 16'h0012, 16'($urandom), 2'b11, lat, rd, bb);
    step();
    d = 16'($urandom);
    a_write = 1'b1; a_addr = 16'h0010; a_wdata = d; a_be = 2'b11;
    step();
    a_addr = 16'h0012; a_wdata = ~d; a_be = 2'b01;
    lat = 0;
    for (int i = 2; i <= 20 && lat == 0; i++) begin
      step();
      if (i == 2) begin
        checks++; if (a_perr !== CHK) begin
          errors++; $display("FAIL cap_perr_set: got %b want %b", a_perr, CHK); end
      end
      if (a_resp === 1'b1) lat = i;
    end
    a_write = 1'b0;
    checks++; if (lat != LAT_A) begin
      errors++; $display("FAIL cap_latency: got %0d want %0d", lat, LAT_A); end
    ref_a[widx(16'h0010)] = d;
    step();
    checks++; if (a_perr !== CHK) begin
      errors++; $display("FAIL cap_perr_sticky: got %b want %b", a_perr, CHK); end
    exp = ref_a[widx(16'h0010)];
    req_a(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp) begin
      errors++; $display("FAIL cap_orig_addr: got %h want %h", rd, exp); end
    step();
    exp = ref_a[widx(16'h0012)];
    req_a(1'b1, 1'b0, 16'h0012, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp) begin
      errors++; $display("FAIL cap_other_untouched: got %h want %h", rd, exp); end
    step();
  endtask

  task automatic test_both_strobes();
    int lat, bb;
    logic [15:0] rd, d, exp;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++; if (a_perr !== 1'b0) begin
      errors++; $display("FAIL both_perr_cleared: got %b want 0", a_perr); end
    d = 16'($urandom);
    req_a(1'b1, 1'b1, 16'h0030, d, 2'b11, lat, rd, bb);
    checks++; if (lat != LAT_A || rd !== 16'h0000) begin
      errors++; $display("FAIL both_as_write: got lat=%0d rdata=%h want %0d 0000", lat, rd, LAT_A); end
    step();
    checks++; if (a_perr !== CHK) begin
      errors++; $display("FAIL both_perr: got %b want %b", a_perr, CHK); end
    exp = ref_a[widx(16'h0030)];
    req_a(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, rd, bb);
    checks++; if (rd !== exp) begin
      errors++; $display("FAIL both_readback: got %h want %h", rd, exp); end
    step();
  endtask

  initial begin
    a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    for (int i = 0; i < 256; i++) known_a[i] = 1'b0;
    test_reset();
    test_write_read();
    test_alias();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_capture();
    test_both_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Runaway guard.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
